// File: rtl/pht_pkg.sv
// Shared definitions for the pattern history table update path.
// Reuses the global PHT index width define when the build provides one.
`ifndef PHT_BITS
`define PHT_BITS 10
`endif

package pht_pkg;

    localparam int PHT_BITS      = `PHT_BITS;
    localparam int PHT_UPD_DEPTH = 4;
    localparam int DROP_CNT_W    = 8;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
    } pht_entry_t;

    // Saturating add of 0..2 dropped updates onto the drop counter.
    function automatic logic [DROP_CNT_W-1:0] drop_sat_add(
        input logic [DROP_CNT_W-1:0] cnt,
        input logic [1:0]            inc
    );
        logic [DROP_CNT_W:0] sum_s;
        sum_s = {1'b0, cnt} + {{(DROP_CNT_W-1){1'b0}}, inc};
        if (sum_s[DROP_CNT_W]) begin
            return {DROP_CNT_W{1'b1}};
        end else begin
            return sum_s[DROP_CNT_W-1:0];
        end
    endfunction

endpackage

// File: rtl/pht_upd_fifo.sv
// Dual-push / single-pop circular queue of PHT updates.
// Writes are compacted by the caller: wr1_en is only ever set together with wr0_en.
module pht_upd_fifo
    import pht_pkg::*;
#(
    parameter int DEPTH = PHT_UPD_DEPTH,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = AW + 1
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          wr0_en,
    input  pht_entry_t    wr0_data,
    input  logic          wr1_en,
    input  pht_entry_t    wr1_data,
    input  logic          pop,
    output pht_entry_t    head_data,
    output logic [CW-1:0] count,
    output logic [CW-1:0] free
);

    logic [AW-1:0] head_r;
    logic [AW-1:0] tail_r;
    logic [AW-1:0] tail_p1_s;
    logic [AW-1:0] tail_nxt_s;
    logic [AW-1:0] head_nxt_s;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_nxt_s;
    logic          pop_ok_s;
    pht_entry_t    mem_r [DEPTH];

    // Pointer/count next-state and free-space computation.
    always_comb begin
        pop_ok_s    = pop && (count_r != {CW{1'b0}});
        tail_p1_s   = tail_r + AW'(1);
        tail_nxt_s  = tail_r;
        head_nxt_s  = head_r;
        if (wr0_en && wr1_en) begin
            tail_nxt_s = tail_r + AW'(2);
        end else if (wr0_en) begin
            tail_nxt_s = tail_p1_s;
        end else begin
            tail_nxt_s = tail_r;
        end
        if (pop_ok_s) begin
            head_nxt_s = head_r + AW'(1);
        end else begin
            head_nxt_s = head_r;
        end
        count_nxt_s = count_r + CW'(wr0_en) + CW'(wr1_en) - CW'(pop_ok_s);
        // A same-cycle pop releases its slot to this cycle's pushes.
        free        = CW'(DEPTH) - count_r + CW'(pop_ok_s);
        count       = count_r;
        head_data   = mem_r[head_r];
    end

    // Queue state and storage registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_r  <= {AW{1'b0}};
            tail_r  <= {AW{1'b0}};
            count_r <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {$bits(pht_entry_t){1'b0}};
            end
        end else begin
            if (wr0_en) begin
                mem_r[tail_r] <= wr0_data;
            end
            if (wr1_en) begin
                mem_r[tail_p1_s] <= wr1_data;
            end
            head_r  <= head_nxt_s;
            tail_r  <= tail_nxt_s;
            count_r <= count_nxt_s;
        end
    end

endmodule

// File: rtl/pht_upd_sched.sv
// PHT update scheduler: merges same-index resolutions, queues them in order
// and issues one update per cycle on the PHT correction port.
module pht_upd_sched
    import pht_pkg::*;
#(
    parameter int DEPTH    = PHT_UPD_DEPTH,
    parameter int PHT_BITS = pht_pkg::PHT_BITS
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  res0_valid_i,
    input  logic [31:0]           res0_pc_i,
    input  logic                  res0_taken_i,
    input  logic                  res1_valid_i,
    input  logic [31:0]           res1_pc_i,
    input  logic                  res1_taken_i,
    output logic                  res_ready_o,
    output logic                  corr_valid_o,
    output logic [31:0]           corr_index_o,
    output logic                  corr_branch_flag_o,
    output logic                  busy_o,
    output logic [DROP_CNT_W-1:0] drop_cnt_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    pht_entry_t            e0_s;
    pht_entry_t            e1_s;
    pht_entry_t            wr0_data_s;
    pht_entry_t            wr1_data_s;
    pht_entry_t            head_s;
    logic                  merge_s;
    logic                  req0_s;
    logic                  req1_s;
    logic                  wr0_en_s;
    logic                  wr1_en_s;
    logic                  pop_s;
    logic [1:0]            drop_n_s;
    logic [CW-1:0]         count_s;
    logic [CW-1:0]         free_s;
    logic [DROP_CNT_W-1:0] drop_cnt_r;

    // Merge same-index pairs (younger wins), then admit requests into free slots in age order.
    always_comb begin
        e0_s       = '{pc: res0_pc_i, taken: res0_taken_i};
        e1_s       = '{pc: res1_pc_i, taken: res1_taken_i};
        pop_s      = (count_s != {CW{1'b0}});
        merge_s    = res0_valid_i && res1_valid_i &&
                     (res0_pc_i[PHT_BITS+1:2] == res1_pc_i[PHT_BITS+1:2]);
        req0_s     = res0_valid_i && !merge_s;
        req1_s     = res1_valid_i;
        wr0_en_s   = 1'b0;
        wr1_en_s   = 1'b0;
        wr0_data_s = e0_s;
        wr1_data_s = e1_s;
        drop_n_s   = 2'd0;
        if (req0_s && req1_s) begin
            if (free_s >= CW'(2)) begin
                wr0_en_s = 1'b1;
                wr1_en_s = 1'b1;
            end else if (free_s == CW'(1)) begin
                wr0_en_s = 1'b1;
                drop_n_s = 2'd1;
            end else begin
                drop_n_s = 2'd2;
            end
        end else if (req0_s || req1_s) begin
            if (req1_s) begin
                wr0_data_s = e1_s;
            end else begin
                wr0_data_s = e0_s;
            end
            if (free_s != {CW{1'b0}}) begin
                wr0_en_s = 1'b1;
            end else begin
                drop_n_s = 2'd1;
            end
        end else begin
            drop_n_s = 2'd0;
        end
    end

    pht_upd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr0_en    (wr0_en_s),
        .wr0_data  (wr0_data_s),
        .wr1_en    (wr1_en_s),
        .wr1_data  (wr1_data_s),
        .pop       (pop_s),
        .head_data (head_s),
        .count     (count_s),
        .free      (free_s)
    );

    // Saturating drop counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt_r <= {DROP_CNT_W{1'b0}};
        end else begin
            drop_cnt_r <= drop_sat_add(drop_cnt_r, drop_n_s);
        end
    end

    // Head entry drives the correction port; outputs are zeroed while the queue is empty.
    always_comb begin
        if (pop_s) begin
            corr_valid_o       = 1'b1;
            corr_index_o       = head_s.pc;
            corr_branch_flag_o = head_s.taken;
        end else begin
            corr_valid_o       = 1'b0;
            corr_index_o       = 32'd0;
            corr_branch_flag_o = 1'b0;
        end
        busy_o      = pop_s;
        res_ready_o = (free_s >= CW'(2));
        drop_cnt_o  = drop_cnt_r;
    end

endmodule

// File: tb/tb_pht_upd_sched.sv
// Bench for pht_upd_sched: vector table plus scoreboard of expected updates.
module tb_pht_upd_sched;
    import pht_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        res0_valid_i, res0_taken_i, res1_valid_i, res1_taken_i;
    logic [31:0] res0_pc_i, res1_pc_i;
    logic        res_ready_o, corr_valid_o, corr_branch_flag_o, busy_o;
    logic [31:0] corr_index_o;
    logic [7:0]  drop_cnt_o;

    typedef struct {
        logic [31:0] pc;
        logic        taken;
    } ent_t;

    typedef struct {
        logic        v0;
        logic [31:0] pc0;
        logic        t0;
        logic        v1;
        logic [31:0] pc1;
        logic        t1;
        logic [31:0] exp_pc;
        logic        exp_t;
    } vec_t;

    int   total = 0;
    int   bad = 0;
    int   mdl_drop = 0;
    ent_t exp_q[$];
    vec_t vecs[6];

    pht_upd_sched #(.DEPTH(DEPTH)) dut (
        .clk                (clk),
        .rst                (rst),
        .res0_valid_i       (res0_valid_i),
        .res0_pc_i          (res0_pc_i),
        .res0_taken_i       (res0_taken_i),
        .res1_valid_i       (res1_valid_i),
        .res1_pc_i          (res1_pc_i),
        .res1_taken_i       (res1_taken_i),
        .res_ready_o        (res_ready_o),
        .corr_valid_o       (corr_valid_o),
        .corr_index_o       (corr_index_o),
        .corr_branch_flag_o (corr_branch_flag_o),
        .busy_o             (busy_o),
        .drop_cnt_o         (drop_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [PHT_BITS-1:0] idx(input logic [31:0] pc);
        return pc[PHT_BITS+1:2];
    endfunction

    task automatic drive(input logic v0, input logic [31:0] pc0, input logic t0,
                         input logic v1, input logic [31:0] pc1, input logic t1);
        res0_valid_i = v0; res0_pc_i = pc0; res0_taken_i = t0;
        res1_valid_i = v1; res1_pc_i = pc1; res1_taken_i = t1;
    endtask

    task automatic idle();
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic check_outputs();
        logic has;
        int   free;
        has  = (exp_q.size() != 0);
        free = DEPTH - exp_q.size() + (has ? 1 : 0);
        chk("corr_valid", {31'd0, corr_valid_o}, {31'd0, has});
        chk("corr_index", corr_index_o, has ? exp_q[0].pc : 32'd0);
        chk("corr_flag", {31'd0, corr_branch_flag_o}, has ? {31'd0, exp_q[0].taken} : 32'd0);
        chk("busy", {31'd0, busy_o}, {31'd0, has});
        chk("res_ready", {31'd0, res_ready_o}, (free >= 2) ? 32'd1 : 32'd0);
        chk("drop_cnt", {24'd0, drop_cnt_o}, 32'(mdl_drop));
    endtask

    // Apply current inputs at the next edge: model retires the head, admits requests in age order.
    task automatic tick();
        int   free;
        ent_t reqs[$];
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        free = DEPTH - exp_q.size();
        if (res0_valid_i && !(res1_valid_i && idx(res0_pc_i) == idx(res1_pc_i)))
            reqs.push_back('{res0_pc_i, res0_taken_i});
        if (res1_valid_i)
            reqs.push_back('{res1_pc_i, res1_taken_i});
        foreach (reqs[k]) begin
            if (free > 0) begin
                exp_q.push_back(reqs[k]);
                free--;
            end else if (mdl_drop < 255) begin
                mdl_drop++;
            end
        end
        @(posedge clk);
        #1;
        idle();
        check_outputs();
    endtask

    initial begin
        vecs[0] = '{1'b1, 32'h0000_1004, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0000_1004, 1'b1};
        vecs[1] = '{1'b1, 32'h0000_0100, 1'b0, 1'b1, 32'h0000_0200, 1'b1, 32'h0000_0100, 1'b0};
        vecs[2] = '{1'b1, 32'h0000_1000, 1'b0, 1'b1, 32'h0000_1000, 1'b1, 32'h0000_1000, 1'b1};
        vecs[3] = '{1'b1, 32'h0000_0010, 1'b1, 1'b1, 32'h0000_1010, 1'b0, 32'h0000_1010, 1'b0};
        vecs[4] = '{1'b0, 32'h0000_0500, 1'b1, 1'b1, 32'h0000_3000, 1'b1, 32'h0000_3000, 1'b1};
        vecs[5] = '{1'b1, 32'h0000_0044, 1'b1, 1'b1, 32'h0000_0048, 1'b0, 32'h0000_0044, 1'b1};

        rst = 1'b0;
        idle();
        #12;
        chk("rst_valid", {31'd0, corr_valid_o}, 32'd0);
        chk("rst_ready", {31'd0, res_ready_o}, 32'd1);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_drop", {24'd0, drop_cnt_o}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_outputs();

        // Single-cycle vectors, each followed by a drain.
        for (int i = 0; i < 6; i++) begin
            drive(vecs[i].v0, vecs[i].pc0, vecs[i].t0, vecs[i].v1, vecs[i].pc1, vecs[i].t1);
            tick();
            chk("vec_valid", {31'd0, corr_valid_o}, 32'd1);
            chk("vec_pc", corr_index_o, vecs[i].exp_pc);
            chk("vec_taken", {31'd0, corr_branch_flag_o}, {31'd0, vecs[i].exp_t});
            for (int k = 0; k < 3; k++) tick();
            chk("vec_drained", {31'd0, busy_o}, 32'd0);
            chk("vec_no_drop", {24'd0, drop_cnt_o}, 32'd0);
        end

        // Overflow: four cycles of dual pushes into a depth-4 queue drop exactly one.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h0000_0400 + 32'(i * 16), i[0], 1'b1, 32'h0000_0408 + 32'(i * 16), ~i[0]);
            tick();
        end
        chk("ovf_ready", {31'd0, res_ready_o}, 32'd0);
        chk("ovf_drop", {24'd0, drop_cnt_o}, 32'd1);
        chk("ovf_full_valid", {31'd0, corr_valid_o}, 32'd1);
        for (int k = 0; k < 6; k++) tick();

        // Sustained overload: drop counter must saturate.
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 32'h0001_0000 + (32'(i) << 3), 1'b1, 1'b1, 32'h0001_0004 + (32'(i) << 3), 1'b0);
            tick();
        end
        chk("sat_drop", {24'd0, drop_cnt_o}, 32'd255);
        for (int k = 0; k < 6; k++) tick();
        chk("sat_hold", {24'd0, drop_cnt_o}, 32'd255);

        // Wrap: single pushes interleaved with idle cycles walk the tail across the end.
        begin
            int pat[10] = '{1, 1, 0, 1, 1, 1, 0, 1, 0, 0};
            int n = 0;
            for (int i = 0; i < 10; i++) begin
                if (pat[i] != 0) begin
                    drive(n[0], 32'h0000_2000 + 32'(n * 4), n[1], ~n[0], 32'h0000_2000 + 32'(n * 4), n[1]);
                    n++;
                end
                tick();
            end
            for (int k = 0; k < 4; k++) tick();
        end

        // Async reset with three entries queued.
        drive(1'b1, 32'h0000_7000, 1'b1, 1'b1, 32'h0000_7004, 1'b0);
        tick();
        drive(1'b1, 32'h0000_7008, 1'b1, 1'b1, 32'h0000_700c, 1'b1);
        tick();
        chk("pre_rst_busy", {31'd0, busy_o}, 32'd1);
        #2 rst = 1'b0;
        #1;
        exp_q.delete();
        mdl_drop = 0;
        chk("arst_valid", {31'd0, corr_valid_o}, 32'd0);
        chk("arst_index", corr_index_o, 32'd0);
        chk("arst_flag", {31'd0, corr_branch_flag_o}, 32'd0);
        chk("arst_busy", {31'd0, busy_o}, 32'd0);
        chk("arst_ready", {31'd0, res_ready_o}, 32'd1);
        chk("arst_drop", {24'd0, drop_cnt_o}, 32'd0);
        #2 rst = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        drive(1'b1, 32'h0000_1004, 1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        chk("post_rst_pc", corr_index_o, 32'h0000_1004);
        for (int k = 0; k < 3; k++) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pht_upd_sched.md
# pht_upd_sched

Update scheduler for the pattern history table. Collects resolved-branch outcomes from the two branch-resolution ports, at most two per cycle. Merges same-cycle updates that hit the same PHT entry, buffers them in a small in-order queue and issues at most one update per cycle on the PHT's single correct port. Sits between the EX-stage branch units and the PHT in IF; the PHT search ports are untouched.

## Interface
- `DEPTH`, 4: queue entries; power of two, ≥ 2.
- `PHT_BITS`, `` `PHT_BITS ``: PHT index width; index = pc[PHT_BITS+1:2].
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `res0_valid_i`  in  1  older resolved branch valid.
- `res0_pc_i`  in  32  older branch PC.
- `res0_taken_i`  in  1  older branch outcome.
- `res1_valid_i`  in  1  younger resolved branch valid.
- `res1_pc_i`  in  32  younger branch PC.
- `res1_taken_i`  in  1  younger branch outcome.
- `res_ready_o`  out  1  two or more free slots this cycle; advisory.
- `corr_valid_o`  out  1  update valid to PHT; PHT consumes it unconditionally.
- `corr_index_o`  out  32  full PC of the update; PHT slices the index.
- `corr_branch_flag_o`  out  1  outcome to train.
- `busy_o`  out  1  queue non-empty.
- `drop_cnt_o`  out  8  saturating count of updates dropped on overflow.

## Operation
- Queue state:
  - head and tail pointers of log2(DEPTH) bits, wrapping modulo DEPTH.
  - count of log2(DEPTH)+1 bits.
  - storage of {pc[31:0], taken} per entry.
- Head entry drives the outputs: `corr_valid_o` = (count != 0), `corr_index_o` = head pc, `corr_branch_flag_o` = head taken. Outputs are 0 when count = 0.
- Pop: every cycle with count != 0; head advances by 1. There is no stall input.
- Merge: both res valid and equal index (pc[PHT_BITS+1:2]) → only res1 is enqueued, because the younger branch wins. Different PCs that alias to the same index also merge.
- Push order: res0 first, then res1.
- Free space for this cycle = DEPTH − count + pop. A same-cycle pop frees its slot.
- Overflow: requests beyond free space are dropped; res1 is dropped before res0. `drop_cnt_o` += number dropped, saturating at 255. Merged-away res0 is not a drop.
- `res_ready_o` = (free space ≥ 2), combinational from count. Requesters may ignore it; dropping is the defined behaviour.
- No FSM beyond queue state. Idle = count 0; drain = count > 0.

## Timing
- Reset (rst = 0, async):
  - count, head, tail, drop_cnt cleared.
  - all storage cleared.
  - outputs: `corr_valid_o` 0, `corr_index_o` 0, `corr_branch_flag_o` 0, `busy_o` 0, `res_ready_o` 1, `drop_cnt_o` 0.
- Reset mid-operation discards queued updates with no partial issue. Deassertion is synchronised externally.
- Latency: an entry pushed at edge N into an empty queue appears on `corr_*` during cycle N+1 and is consumed at edge N+1.
- Throughput: 1 update/cycle. A sustained 2/cycle input fills DEPTH, then drops.
- Pointer wrap: tail at DEPTH−1 with 2 pushes writes slots DEPTH−1 and 0.
- Full (count = DEPTH) with no push: pop proceeds and count decrements.
- Full with 1 push and 1 pop: accepted, count unchanged.

## Structure
- Shared package `pht_pkg`:
  - `PHT_BITS` (existing global define, reused).
  - entry typedef {pc, taken}.
  - `PHT_UPD_DEPTH` default.
  - drop counter width constant.
- One natural sub-module, `pht_upd_fifo`: dual-push/single-pop circular queue with free-space output.
- Top level holds merge logic, drop accounting and output mapping.
- Target ~180–260 lines total.

## Test plan
- Single update: after reset, res0 {pc=0x0000_1004, taken=1} at edge 0 → `corr_valid_o`=1, `corr_index_o`=0x0000_1004, `corr_branch_flag_o`=1 in cycle 1 only. `busy_o` low from cycle 2.
- Ordering: res0 0x100/taken=0 and res1 0x200/taken=1 in the same cycle → 0x100/0 in cycle 1, then 0x200/1 in cycle 2.
- Merge: res0 0x1000/taken=0 and res1 0x1000/taken=1 in the same cycle → exactly one update, 0x1000/1; `drop_cnt_o` stays 0.
- Overflow: DEPTH=4, dual pushes with distinct indices on 4 consecutive cycles (8 requests) → updates issued in order, none lost until count hits DEPTH; `drop_cnt_o` equals the number rejected; `res_ready_o` deasserts while free space < 2; 255 + more drops holds at 255.
- Wrap: 6 single pushes with interleaved pops, walking tail across DEPTH−1→0 → issue order equals push order and no duplicates.
- Async reset: assert rst low mid-cycle with 3 entries queued → outputs drop to reset values immediately; after release, no stale update is issued.
